start_text_renderer: RTL and testbench
======================================

# start_text_renderer

Reads the 8x16 glyph ROM that holds the start-screen message (14 characters: "PRESS TO START", 16 bytes per character) and turns it into a per-pixel `text_on` flag for the VGA color mapper. It runs one pixel per `Clk` from the `DrawX`/`DrawY` scan coordinates. It issues ROM addresses, selects the glyph bit, and blinks the message at a frame-counted rate. It sits between the VGA controller and the color mapper, and is active only while the game is in its start state.

## Interface
- `TEXT_X`, default 264: left pixel column of the message.
- `TEXT_Y`, default 232: top pixel row of the message.
- `NUM_CHARS`, default 14: number of characters in the ROM; 1..128.
- `SCALE_SHIFT`, default 0: glyph magnification is 2^SCALE_SHIFT; legal values 0 or 1.
- `BLINK_FRAMES`, default 30: frames per visible/hidden half-period; ≥1.
- `Clk` input, 1 bit: pixel clock; all state is rising-edge triggered.
- `Reset_n` input, 1 bit: asynchronous, active-low reset.
- `DrawX` input, 10 bits: current pixel column.
- `DrawY` input, 10 bits: current pixel row.
- `frame_start` input, 1 bit: one-cycle pulse at the start of each frame.
- `enable` input, 1 bit: high while the start screen is shown.
- `rom_addr` output, 11 bits: glyph ROM address, computed as char*16 + row.
- `rom_data` input, 8 bits: ROM byte, combinational from `rom_addr`; bit 7 is the leftmost pixel.
- `text_on` output, 1 bit: the current pipelined pixel is lit text.

## Operation
- **Region test (stage 0, combinational):**
  - relX = DrawX − TEXT_X and relY = DrawY − TEXT_Y, both computed 11 bits wide.
  - in_region = (DrawX ≥ TEXT_X) && (DrawX < TEXT_X + NUM_CHARS·8·2^S) && (DrawY ≥ TEXT_Y) && (DrawY < TEXT_Y + 16·2^S), where S = SCALE_SHIFT.
- **Glyph indexing:**
  - char = relX >> (3+S)
  - col = (relX >> S) & 7
  - row = (relY >> S) & 15
- **Stage 1 registers:**
  - `rom_addr` ← in_region ? {char, row[3:0]} : 0.
  - col_q ← col.
  - in_q ← in_region && enable && visible.
- **Stage 2 register:** `text_on` ← in_q && rom_data[7 − col_q].
- **Blank glyphs:** space characters are blank in the ROM. They need no special casing.
- **Blink state machine:** two states, VISIBLE and HIDDEN, held in the `visible` bit, plus a frame counter of width ceil(log2(BLINK_FRAMES)).
  - When `enable` is high and `frame_start` pulses: if counter = BLINK_FRAMES−1, the counter goes to 0 and `visible` toggles. Otherwise the counter increments.
  - When `enable` is low: the counter goes to 0 and `visible` goes to 1, so the message appears immediately on the next enable. `enable` low takes priority over a simultaneous `frame_start`.
- **Reset (asynchronous):** `rom_addr`=0, col_q=0, in_q=0, `text_on`=0, counter=0, `visible`=1. Asserting reset mid-line clears `text_on` immediately, without waiting for a clock edge.

## Timing
- **`rom_addr` latency:** valid 1 edge after `DrawX`/`DrawY` are presented.
- **`text_on` latency:** valid 2 edges after `DrawX`/`DrawY` are presented. The color mapper delays its own coordinates by 2 cycles to stay aligned.
- **Throughput:** one pixel per cycle with no stalls. Back-to-back characters need no gap.
- **Blink edge:** a `visible` change takes effect on in_q 1 edge after the `frame_start` edge, and on `text_on` 2 edges after it.
- **Region edges:**
  - DrawX = TEXT_X is inside the message.
  - DrawX = TEXT_X + NUM_CHARS·8·2^S is outside it.
  - DrawX < TEXT_X must not alias through the 11-bit subtraction wrap; the explicit ≥ compare guards this.

## Test plan
- **Top-left pixel.** Defaults, `enable`=1. Apply DrawX=264, DrawY=234 (row 2 of 'P').
  - After 1 edge: `rom_addr` = 2.
  - ROM returns 0xFC; after 2 edges: `text_on` = 1.
  - Same line at DrawX=270 and 271 (cols 6 and 7): `text_on` = 0 for both.
- **Region edges.** DrawY=234 held.
  - DrawX=263: `rom_addr` = 0 and `text_on` = 0.
  - DrawX=375 (char 13 'T', col 7, rom_data 0xFF): `rom_addr` = 210 and `text_on` = 1.
  - DrawX=376: `text_on` = 0.
  - DrawY=248 at DrawX=264: `text_on` = 0.
- **Blink.** `BLINK_FRAMES`=30; sweep pixel (264,234) every frame.
  - `text_on` pulses in frames 0–29 and is 0 in frames 30–59.
  - `text_on` returns in frame 60.
- **Enable override.** Drop `enable` while HIDDEN, in the same cycle as a `frame_start` pulse.
  - Counter becomes 0 and `visible` becomes 1.
  - Re-raise `enable`: the next in-region lit pixel gives `text_on` = 1.
- **Scale.** SCALE_SHIFT=1. Apply DrawX=264+16, DrawY=232+4.
  - `rom_addr` = 18 (char 1 'R', row 2).
  - DrawX=264+15, DrawY=236 gives char 0, col 7.
- **Async reset.** Pull `Reset_n` low mid-way through a lit run.
  - `text_on` falls before the next `Clk` edge.
  - After release, outputs resume 2 edges after valid coordinates, with `visible` = 1.

Source files
------------

// File: rtl/start_text_renderer.sv
// Start-screen text renderer: maps DrawX/DrawY onto the "PRESS TO START" glyph ROM
// and produces a blinking per-pixel text_on flag two cycles behind the scan coordinates.
module start_text_renderer #(
  parameter int unsigned TEXT_X       = 264,
  parameter int unsigned TEXT_Y       = 232,
  parameter int unsigned NUM_CHARS    = 14,
  parameter int unsigned SCALE_SHIFT  = 0,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        enable,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        text_on
);

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned CHAR_W   = 7;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned X_END    = TEXT_X + ((NUM_CHARS * 8) << SCALE_SHIFT);
  localparam int unsigned Y_END    = TEXT_Y + (16 << SCALE_SHIFT);
  localparam int unsigned CHAR_SH  = 3 + SCALE_SHIFT;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {
    ST_VISIBLE = 1'b0,
    ST_HIDDEN  = 1'b1
  } blink_state_e;

  blink_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             visible_c;

  logic [COORD_W-1:0] rel_x_c, rel_y_c;
  logic               in_region_c;
  logic [CHAR_W-1:0]  char_c;
  logic [COL_W-1:0]   col_c;
  logic [ROW_W-1:0]   row_c;

  logic [10:0]        rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               in_q, in_d;
  logic               text_on_q, text_on_d;

  // Stage 0: region test on full-width compares so left-of-message pixels never alias
  always_comb begin
    rel_x_c     = COORD_W'({1'b0, DrawX}) - COORD_W'(TEXT_X);
    rel_y_c     = COORD_W'({1'b0, DrawY}) - COORD_W'(TEXT_Y);
    in_region_c = (32'(DrawX) >= TEXT_X) && (32'(DrawX) < X_END) &&
                  (32'(DrawY) >= TEXT_Y) && (32'(DrawY) < Y_END);
    char_c      = CHAR_W'(rel_x_c >> CHAR_SH);
    col_c       = COL_W'(rel_x_c >> SCALE_SHIFT);
    row_c       = ROW_W'(rel_y_c >> SCALE_SHIFT);
  end

  // Blink FSM: state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_VISIBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Blink FSM: next state; disable forces an immediately visible restart
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_VISIBLE;
      cnt_d   = '0;
    end else if (frame_start) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = (state_q == ST_VISIBLE) ? ST_HIDDEN : ST_VISIBLE;
      end else begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
      end
    end
  end

  // Blink FSM: outputs
  always_comb begin
    visible_c = 1'b0;
    if (state_q == ST_VISIBLE) begin
      visible_c = 1'b1;
    end
  end

  // Stage 1 and stage 2 next values
  always_comb begin
    rom_addr_d = '0;
    if (in_region_c) begin
      rom_addr_d = {char_c, row_c};
    end
    col_d     = col_c;
    in_d      = in_region_c && enable && visible_c;
    text_on_d = in_q && rom_data[3'd7 - col_q];
  end

  // Pixel pipeline registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q <= '0;
      col_q      <= '0;
      in_q       <= 1'b0;
      text_on_q  <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      col_q      <= col_d;
      in_q       <= in_d;
      text_on_q  <= text_on_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign text_on  = text_on_q;

endmodule

// File: tb/tb_start_text_renderer.sv
// Directed bench for start_text_renderer: default instance plus a 2x-scaled instance,
// each fed by a small model of the "PRESS TO START" glyph ROM (row 2 only populated).
module tb_start_text_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  draw_x, draw_y;
  logic        frame_start, enable;
  logic [10:0] rom_addr, rom_addr_s;
  logic [7:0]  rom_data, rom_data_s;
  logic        text_on, text_on_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [10:0] a);
    logic [6:0] ch;
    logic [3:0] r;
    ch = a[10:4];
    r  = a[3:0];
    if (r != 4'd2) return 8'h00;
    case (ch)
      7'd0, 7'd1, 7'd12:  return 8'hFC;
      7'd2:               return 8'hFE;
      7'd3, 7'd4, 7'd9:   return 8'h7C;
      7'd7:               return 8'h7C;
      7'd6, 7'd10, 7'd13: return 8'hFF;
      7'd11:              return 8'h38;
      default:            return 8'h00;
    endcase
  endfunction

  assign rom_data   = glyph(rom_addr);
  assign rom_data_s = glyph(rom_addr_s);

  start_text_renderer dut (
    .Clk(clk), .Reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y),
    .frame_start(frame_start), .enable(enable),
    .rom_addr(rom_addr), .rom_data(rom_data), .text_on(text_on)
  );

  start_text_renderer #(.SCALE_SHIFT(1)) dut_s (
    .Clk(clk), .Reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y),
    .frame_start(frame_start), .enable(enable),
    .rom_addr(rom_addr_s), .rom_data(rom_data_s), .text_on(text_on_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic px(input int x, input int y, input int exp_addr, input int exp_on,
                    input string tag);
    draw_x = 10'(x);
    draw_y = 10'(y);
    step();
    chk({tag, "/addr"}, rom_addr, 11'(exp_addr));
    step();
    chk({tag, "/on"}, {10'd0, text_on}, 11'(exp_on));
  endtask

  task automatic pulse();
    draw_x      = 10'd0;
    draw_y      = 10'd0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    frame_start = 1'b0;
    draw_x      = 10'd264;
    draw_y      = 10'd234;
    step();
    step();
    chk("reset addr", rom_addr, 11'd0);
    chk("reset on", {10'd0, text_on}, 11'd0);
    rst_n = 1'b1;

    px(264, 234, 2, 1, "top-left");
    px(270, 234, 2, 0, "col6");
    px(271, 234, 2, 0, "col7");
    px(263, 234, 0, 0, "left edge");
    px(375, 234, 210, 1, "last col");
    px(376, 234, 0, 0, "right edge");
    px(264, 248, 0, 0, "bottom edge");
    px(266, 233, 1, 0, "row1 blank");

    draw_x = 10'd280;
    draw_y = 10'd236;
    step();
    chk("scale addr R", rom_addr_s, 11'd18);
    step();
    chk("scale on R", {10'd0, text_on_s}, 11'd1);
    draw_x = 10'd279;
    step();
    chk("scale addr c0c7", rom_addr_s, 11'd2);
    step();
    chk("scale on c0c7", {10'd0, text_on_s}, 11'd0);
    draw_x = 10'd274;
    step();
    step();
    chk("scale on c0c5", {10'd0, text_on_s}, 11'd1);

    for (int f = 0; f <= 60; f++) begin
      if (f > 0) pulse();
      px(264, 234, 2, ((f < 30) || (f >= 60)) ? 1 : 0, $sformatf("blink f%0d", f));
    end

    for (int i = 0; i < 31; i++) pulse();
    px(264, 234, 2, 0, "hidden pre");

    draw_x      = 10'd264;
    draw_y      = 10'd234;
    enable      = 1'b0;
    frame_start = 1'b1;
    step();
    enable      = 1'b1;
    frame_start = 1'b0;
    step();
    chk("override gate", {10'd0, text_on}, 11'd0);
    step();
    chk("override relit", {10'd0, text_on}, 11'd1);

    for (int i = 0; i < 29; i++) pulse();
    px(264, 234, 2, 1, "override cnt29");
    pulse();
    px(264, 234, 2, 0, "override cnt30");

    enable = 1'b0;
    step();
    enable = 1'b1;
    draw_x = 10'd264;
    draw_y = 10'd234;
    step();
    step();
    chk("pre-reset lit", {10'd0, text_on}, 11'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async clear on", {10'd0, text_on}, 11'd0);
    chk("async clear addr", rom_addr, 11'd0);
    step();
    chk("reset held on", {10'd0, text_on}, 11'd0);
    rst_n = 1'b1;
    step();
    chk("post-reset addr", rom_addr, 11'd2);
    step();
    chk("post-reset on", {10'd0, text_on}, 11'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
